// File: rtl/policy_action_dispatch_if.sv
// Handshake bundle between the verdict FIFO, the egress path and the host report path.
// The dispatch block connects as master; the surrounding environment connects as slave.
interface policy_action_dispatch_if;
  logic [138:0] ob_dout;
  logic         ob_valid;
  logic         ob_rd_en;
  logic [112:0] fwd_data;
  logic         fwd_valid;
  logic         fwd_ready;
  logic [63:0]  rpt_data;
  logic         rpt_valid;
  logic         rpt_ready;

  modport master (
    input  ob_dout, ob_valid, fwd_ready, rpt_ready,
    output ob_rd_en, fwd_data, fwd_valid, rpt_data, rpt_valid
  );

  modport slave (
    output ob_dout, ob_valid, fwd_ready, rpt_ready,
    input  ob_rd_en, fwd_data, fwd_valid, rpt_data, rpt_valid
  );
endinterface

// File: rtl/policy_action_dispatch.sv
// Pops verdict records and either forwards the descriptor, drops it, or drops it and reports usage.
// Reports are rate-limited per counter ID; saturating statistics track every outcome.
module policy_action_dispatch #(
  parameter logic [23:0] SUPP_WIN = 24'd1000,
  parameter int          CNT_W    = 32
) (
  input  logic                    asclk,
  input  logic                    aresetn,
  input  logic [23:0]             timer,
  policy_action_dispatch_if.master bus,
  input  logic                    stat_clr,
  output logic [CNT_W-1:0]        fwd_cnt,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic [CNT_W-1:0]        rpt_cnt,
  output logic [CNT_W-1:0]        supp_cnt,
  output logic [CNT_W-1:0]        bad_cnt
);

  typedef enum logic [1:0] {IDLE, FWD, RPT} state_t;

  state_t state, state_nxt;

  logic [15:0]  len;
  logic [95:0]  pkt_id;
  logic [2:0]   policy;
  logic         ul;
  logic [13:0]  cnt_id;
  logic [2:0]   quo_en;
  logic [2:0]   thres_en;
  logic         cnt_en;
  logic [1:0]   unused_rsvd;

  assign len         = bus.ob_dout[15:0];
  assign pkt_id      = bus.ob_dout[111:16];
  assign policy      = bus.ob_dout[114:112];
  assign ul          = bus.ob_dout[115];
  assign cnt_id      = bus.ob_dout[129:116];
  assign quo_en      = bus.ob_dout[132:130];
  assign thres_en    = bus.ob_dout[135:133];
  assign unused_rsvd = bus.ob_dout[137:136];
  assign cnt_en      = bus.ob_dout[138];

  logic [13:0]  last_id;
  logic [23:0]  last_t;
  logic         last_vld;
  logic [23:0]  age;
  logic         pop, to_drop, to_rpt, to_fwd, is_bad, supp_hit;
  logic         fwd_done, rpt_done;
  logic [112:0] fwd_data_q;
  logic [63:0]  rpt_data_q;

  assign pop      = bus.ob_valid && (state == IDLE) && aresetn;
  assign bus.ob_rd_en = pop;

  assign to_drop  = cnt_en && ((policy == 3'd1) || (policy == 3'd2));
  assign to_rpt   = cnt_en && (policy == 3'd2);
  assign to_fwd   = !to_drop;
  assign is_bad   = cnt_en && to_fwd && (policy != 3'd4);

  // Modular subtraction keeps the window correct across timer wrap.
  assign age      = timer - last_t;
  assign supp_hit = (SUPP_WIN != 24'd0) && last_vld && (cnt_id == last_id) && (age < SUPP_WIN);

  assign fwd_done = (state == FWD) && bus.fwd_ready;
  assign rpt_done = (state == RPT) && bus.rpt_ready;

  always_ff @(posedge asclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.fwd_valid = 1'b0;
    bus.rpt_valid = 1'b0;
    case (state)
      IDLE: begin
        if (pop) begin
          if (to_fwd)                 state_nxt = FWD;
          else if (to_rpt && !supp_hit) state_nxt = RPT;
        end
      end
      FWD: begin
        bus.fwd_valid = 1'b1;
        if (bus.fwd_ready) state_nxt = IDLE;
      end
      RPT: begin
        bus.rpt_valid = 1'b1;
        if (bus.rpt_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Payloads and the suppression history are captured only on the pop edge.
  always_ff @(posedge asclk) begin
    if (!aresetn) begin
      fwd_data_q <= '0;
      rpt_data_q <= '0;
      last_id    <= '0;
      last_t     <= '0;
      last_vld   <= 1'b0;
    end else if (pop) begin
      if (to_fwd) fwd_data_q <= {ul, pkt_id, len};
      if (to_rpt && !supp_hit) begin
        rpt_data_q <= {len, timer, policy, ul, thres_en, quo_en, cnt_id};
        last_id    <= cnt_id;
        last_t     <= timer;
        last_vld   <= 1'b1;
      end
    end
  end

  assign bus.fwd_data = fwd_data_q;
  assign bus.rpt_data = rpt_data_q;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && !(&v)) return v + CNT_W'(1);
    return v;
  endfunction

  // Clear wins over any increment landing on the same edge.
  always_ff @(posedge asclk) begin
    if (!aresetn || stat_clr) begin
      fwd_cnt  <= '0;
      drop_cnt <= '0;
      rpt_cnt  <= '0;
      supp_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      fwd_cnt  <= bump(fwd_cnt,  fwd_done);
      drop_cnt <= bump(drop_cnt, pop && to_drop);
      rpt_cnt  <= bump(rpt_cnt,  rpt_done);
      supp_cnt <= bump(supp_cnt, pop && to_rpt && supp_hit);
      bad_cnt  <= bump(bad_cnt,  pop && is_bad);
    end
  end

endmodule
